// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern-recognition path: default image geometry,
// derived field widths and the per-row summary record.
package pattern_pkg;

  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int CNT_W = $clog2(IMG_WIDTH + 1);

  typedef struct packed {
    logic [ROW_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
  } row_summary_t;

endpackage

// File: rtl/row_summary_fifo.sv
// Synchronous first-word-fall-through FIFO for row summaries. The element type is a
// parameter so a top built for a smaller image can store narrower records.
module row_summary_fifo
  import pattern_pkg::*;
#(
  parameter type T     = row_summary_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/edge_row_profiler.sv
// Binarises the Sobel-Y stream against a per-frame threshold, emits one {row, count}
// summary per raster row through a FIFO and reports the strongest row of each frame.
module edge_row_profiler #(
  parameter int IMG_WIDTH  = pattern_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = pattern_pkg::IMG_HEIGHT,
  parameter int W          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           x_valid,
  output logic                           x_ready,
  input  logic [W-1:0]                   x_data,
  input  logic [W-1:0]                   threshold,
  output logic                           row_valid,
  input  logic                           row_ready,
  output logic [$clog2(IMG_HEIGHT)-1:0]  row_index,
  output logic [$clog2(IMG_WIDTH+1)-1:0] row_count,
  output logic                           frame_done,
  output logic [$clog2(IMG_HEIGHT)-1:0]  max_row,
  output logic [$clog2(IMG_WIDTH+1)-1:0] max_count
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int CNT_W = $clog2(IMG_WIDTH + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic [ROW_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
  } summary_t;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [W-1:0]     thr_q;
  logic [CNT_W-1:0] row_acc;
  logic [ROW_W-1:0] run_max_row;
  logic [CNT_W-1:0] run_max_cnt;

  logic             accept;
  logic             at_col_last;
  logic             at_row_last;
  logic             first_pix;
  logic [W-1:0]     thr_eff;
  logic             is_edge;
  logic [CNT_W-1:0] row_total;
  logic             push;
  logic             frame_end;
  logic             new_max;
  logic [ROW_W-1:0] final_row;
  logic [CNT_W-1:0] final_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  summary_t         push_data;
  summary_t         head;

  assign at_col_last = (col == COL_LAST);
  assign at_row_last = (row == ROW_LAST);
  assign first_pix   = (col == '0) && (row == '0);

  // Only the row-closing pixel can stall, and only on the registered full flag,
  // so a summary is never dropped and a same-cycle pop does not release the stall.
  assign x_ready = !(at_col_last && fifo_full);
  assign accept  = x_valid && x_ready;

  // Pixel (0,0) is judged with the live threshold; the rest of the frame uses the latched copy.
  assign thr_eff   = first_pix ? threshold : thr_q;
  assign is_edge   = (x_data >= thr_eff);
  assign row_total = row_acc + CNT_W'(is_edge);

  assign push      = accept && at_col_last;
  assign frame_end = push && at_row_last;
  assign push_data = '{idx: row, cnt: row_total};

  // The closing row of a frame must take part in the frame max in the same cycle.
  assign new_max   = (row_total > run_max_cnt);
  assign final_row = new_max ? row : run_max_row;
  assign final_cnt = new_max ? row_total : run_max_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col         <= '0;
      row         <= '0;
      thr_q       <= '0;
      row_acc     <= '0;
      run_max_row <= '0;
      run_max_cnt <= '0;
      max_row     <= '0;
      max_count   <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (accept) begin
        if (first_pix) thr_q <= threshold;
        if (at_col_last) begin
          col     <= '0;
          row     <= at_row_last ? '0 : row + 1'b1;
          row_acc <= '0;
        end else begin
          col     <= col + 1'b1;
          row_acc <= row_total;
        end
      end
      if (frame_end) begin
        max_row     <= final_row;
        max_count   <= final_cnt;
        run_max_row <= '0;
        run_max_cnt <= '0;
      end else if (push && new_max) begin
        run_max_row <= row;
        run_max_cnt <= row_total;
      end
    end
  end

  row_summary_fifo #(
    .T     (summary_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_data),
    .pop   (row_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign row_valid = !fifo_empty;
  assign row_index = head.idx;
  assign row_count = head.cnt;

endmodule

// File: tb/tb_edge_row_profiler.sv
// Bench for edge_row_profiler on an 8x4 image: table vectors, hand-written corner
// sequences and randomised frames checked against a per-frame counting model.
module tb_edge_row_profiler;

  localparam int IW = 8;
  localparam int IH = 4;
  localparam int NP = IW * IH;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x_valid;
  logic       x_ready;
  logic [7:0] x_data;
  logic [7:0] threshold;
  logic       row_valid;
  logic       row_ready;
  logic [1:0] row_index;
  logic [3:0] row_count;
  logic       frame_done;
  logic [1:0] max_row;
  logic [3:0] max_count;

  always #5 clk = ~clk;

  edge_row_profiler #(
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH),
    .W          (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_data     (x_data),
    .threshold  (threshold),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_index  (row_index),
    .row_count  (row_count),
    .frame_done (frame_done),
    .max_row    (max_row),
    .max_count  (max_count)
  );

  typedef struct {
    int idx;
    int cnt;
  } summ_t;

  typedef struct {
    logic [7:0] pixv;
    int         exp_cnt;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] pix [NP];
  summ_t      got [$];
  summ_t      exp_q [$];
  int         exp_max_row;
  int         exp_max_cnt;
  bit         rr_rand = 1'b0;
  vec_t       tv [IH];

  // A summary is consumed at the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (rst_n && row_valid && row_ready)
      got.push_back('{idx: int'(row_index), cnt: int'(row_count)});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int budget = 200;
    x_valid = 1'b1;
    x_data  = d;
    while (!x_ready && budget > 0) begin
      if (rr_rand) row_ready = 1'($urandom_range(0, 1));
      step();
      budget--;
    end
    if (!x_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: x_ready stayed 0 for 200 cycles");
      x_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  // Reference: count pixels >= frame threshold per row; strongest row by strict >.
  task automatic build_expect(input logic [7:0] thr);
    exp_q.delete();
    exp_max_row = 0;
    exp_max_cnt = 0;
    for (int r = 0; r < IH; r++) begin
      int cnt = 0;
      for (int c = 0; c < IW; c++)
        if (pix[r*IW + c] >= thr) cnt++;
      exp_q.push_back('{idx: r, cnt: cnt});
      if (cnt > exp_max_cnt) begin
        exp_max_cnt = cnt;
        exp_max_row = r;
      end
    end
  endtask

  task automatic drain(input int n);
    int budget = 60;
    while (got.size() < n && budget > 0) begin
      step();
      budget--;
    end
    repeat (3) step();
  endtask

  task automatic compare_summaries(input string tag);
    check({tag, "_n_summaries"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s_idx%0d", tag, i), got[i].idx, exp_q[i].idx);
      check($sformatf("%s_cnt%0d", tag, i), got[i].cnt, exp_q[i].cnt);
    end
  endtask

  task automatic run_frame(input logic [7:0] thr0, input logic [7:0] thr_mid, input bit rnd,
                           input string tag);
    build_expect(thr0);
    got.delete();
    rr_rand = rnd;
    for (int i = 0; i < NP; i++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 1)) step();
        row_ready = 1'($urandom_range(0, 1));
      end
      threshold = (i == 0) ? thr0 : thr_mid;
      send(pix[i]);
    end
    check({tag, "_frame_done"}, frame_done, 1);
    check({tag, "_max_row"}, max_row, exp_max_row);
    check({tag, "_max_count"}, max_count, exp_max_cnt);
    step();
    check({tag, "_frame_done_off"}, frame_done, 0);
    rr_rand   = 1'b0;
    row_ready = 1'b1;
    drain(exp_q.size());
    compare_summaries(tag);
  endtask

  initial begin
    tv[0] = '{pixv: 8'h3F, exp_cnt: 0};
    tv[1] = '{pixv: 8'h40, exp_cnt: 8};
    tv[2] = '{pixv: 8'h41, exp_cnt: 8};
    tv[3] = '{pixv: 8'hFF, exp_cnt: 8};

    rst_n     = 1'b0;
    x_valid   = 1'b0;
    x_data    = '0;
    threshold = '0;
    row_ready = 1'b1;
    repeat (3) step();
    check("reset_row_valid", row_valid, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_max_count", max_count, 0);
    check("reset_max_row", max_row, 0);
    check("reset_x_ready", x_ready, 1);
    rst_n = 1'b1;
    step();

    // Row r carries r+1 saturated pixels.
    for (int i = 0; i < NP; i++) pix[i] = ((i % IW) <= (i / IW)) ? 8'hFF : 8'h10;
    run_frame(8'h80, 8'h80, 1'b0, "known");
    check("known_max_row_const", max_row, 3);
    check("known_max_count_const", max_count, 4);

    for (int i = 0; i < NP; i++)
      pix[i] = (((i / IW) == 1 || (i / IW) == 2) && (i % IW) < 5) ? 8'hFF : 8'h10;
    run_frame(8'h80, 8'h80, 1'b0, "ties");
    check("ties_max_row_const", max_row, 1);
    check("ties_max_count_const", max_count, 5);

    for (int i = 0; i < NP; i++) pix[i] = tv[i / IW].pixv;
    run_frame(8'h40, 8'h40, 1'b0, "thr_bound");
    for (int r = 0; r < IH && r < got.size(); r++)
      check($sformatf("thr_table_row%0d", r), got[r].cnt, tv[r].exp_cnt);

    for (int i = 0; i < NP; i++) pix[i] = 8'h3F;
    run_frame(8'h40, 8'h00, 1'b0, "thr_hold");
    run_frame(8'h00, 8'h00, 1'b0, "thr_next");

    for (int f = 0; f < 4; f++) begin
      logic [7:0] t0;
      logic [7:0] tm;
      t0 = 8'($urandom_range(1, 254));
      tm = 8'($urandom_range(0, 255));
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 1) == 1)
          pix[i] = 8'(int'(t0) + $urandom_range(0, 2) - 1);
        else
          pix[i] = 8'($urandom_range(0, 255));
      end
      run_frame(t0, tm, 1'b1, $sformatf("rand%0d", f));
    end

    // Backpressure: five rows with the consumer stalled.
    got.delete();
    row_ready = 1'b0;
    threshold = 8'h80;
    for (int i = 0; i < 39; i++) begin
      if (i == 31) check("bp_ready_3_pending", x_ready, 1);
      send(8'hFF);
    end
    check("bp_ready_full", x_ready, 0);
    x_valid = 1'b1;
    x_data  = 8'hFF;
    repeat (3) step();
    check("bp_ready_held", x_ready, 0);
    check("bp_row_valid", row_valid, 1);
    row_ready = 1'b1;
    check("bp_no_same_cycle_release", x_ready, 0);
    send(8'hFF);
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back('{idx: k % IH, cnt: 8});
    drain(5);
    compare_summaries("bp");

    // Reset in the middle of row 2 with an undelivered summary queued.
    row_ready = 1'b0;
    for (int i = 0; i < IW + 3; i++) send(8'hFF);
    check("mid_pending", row_valid, 1);
    rst_n = 1'b0;
    step();
    step();
    check("mid_reset_row_valid", row_valid, 0);
    check("mid_reset_x_ready", x_ready, 1);
    check("mid_reset_max_count", max_count, 0);
    rst_n = 1'b1;
    row_ready = 1'b1;
    step();
    for (int i = 0; i < NP; i++) pix[i] = ((i % IW) <= (i / IW)) ? 8'hFF : 8'h10;
    run_frame(8'h80, 8'h80, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
